data_mem_dma: RTL and testbench

- Block-copy bus initiator on the data-memory port, driving the same addr / w_data / w_ena / r_ena / sign_mask / r_data / clk_stall signal set as the CPU.
- Copies LEN 32-bit words from a source to a destination address, one read then one write per word, and honours the responder's stall.
- Sits beside the CPU behind a request/grant mux and runs from the undivided system clock, as the data memory does.

---
 rtl/data_mem_dma.sv | 156 +++++++++++++++
 tb/tb_data_mem_dma.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_dma.sv
// data_mem_dma: block-copy initiator on the data-memory port.
// Copies len_i 32-bit words from src_addr_i to dst_addr_i in ascending order.
// Each word is one read followed by one write. Every access follows the
// REQ / WAIT0 / WAIT protocol and honours the responder's stall.
// Ports:
//   clk_i, reset_n_i             undivided system clock, async active-low reset
//   start_i, abort_i             copy start pulse (IDLE only), word-boundary abort
//   src_addr_i, dst_addr_i       word-aligned byte addresses
//   len_i                        number of words to copy
//   bus_req_o, bus_gnt_i         request/grant handshake with the port mux
//   mem_*                        data-memory bus (same signal set as the CPU)
//   busy_o, done_o, aborted_o    status; done_o is a one-cycle pulse
//   count_o                      words completed in the current/last copy
module data_mem_dma #(
  parameter int unsigned LEN_W     = 16,
  parameter logic [3:0]  WORD_MASK = 4'b1111,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             bus_req_o,
  input  logic             bus_gnt_i,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_w_data_o,
  output logic             mem_w_ena_o,
  output logic             mem_r_ena_o,
  output logic [3:0]       mem_sign_mask_o,
  input  logic [31:0]      mem_r_data_i,
  input  logic             mem_clk_stall_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [LEN_W-1:0] count_o
);

  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  typedef enum logic [3:0] {
    IDLE, ARB, RD_REQ, RD_WAIT0, RD_WAIT, WR_REQ, WR_WAIT0, WR_WAIT, DONE
  } state_t;

  state_t           state;
  logic [31:0]      src_q;   // address of the current word's read
  logic [31:0]      dst_q;   // address of the current word's write
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_inc;

  // Every access is a full word; the encoding never changes at run time.
  assign mem_sign_mask_o = WORD_MASK;

  assign count_inc = count_o + LEN_W'(1);

  // Copy sequencer. Outputs are registered and set on the edge entering the
  // state that owns them, so enables are high for REQ, WAIT0 and WAIT.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      bus_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_w_data_o <= '0;
      mem_w_ena_o  <= 1'b0;
      mem_r_ena_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      aborted_o    <= 1'b0;
      count_o      <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            count_o   <= '0;
            aborted_o <= 1'b0;
            if (len_i != '0) begin
              src_q     <= src_addr_i;
              dst_q     <= dst_addr_i;
              len_q     <= len_i;
              bus_req_o <= 1'b1;
              busy_o    <= 1'b1;
              state     <= ARB;
            end else begin
              // Empty copy: report completion without touching the bus.
              done_o <= 1'b1;
            end
          end
        end

        ARB: begin
          if (abort_i) begin
            bus_req_o <= 1'b0;
            done_o    <= 1'b1;
            aborted_o <= 1'b1;
            state     <= DONE;
          end else if (bus_gnt_i) begin
            mem_addr_o  <= src_q;
            mem_r_ena_o <= 1'b1;
            state       <= RD_REQ;
          end
        end

        RD_REQ:   state <= RD_WAIT0;
        // Stall is not yet valid in the first wait cycle.
        RD_WAIT0: state <= RD_WAIT;

        RD_WAIT: begin
          if (!mem_clk_stall_i) begin
            mem_r_ena_o  <= 1'b0;
            mem_w_data_o <= mem_r_data_i;
            mem_addr_o   <= dst_q;
            mem_w_ena_o  <= 1'b1;
            state        <= WR_REQ;
          end
        end

        WR_REQ:   state <= WR_WAIT0;
        WR_WAIT0: state <= WR_WAIT;

        WR_WAIT: begin
          if (!mem_clk_stall_i) begin
            mem_w_ena_o <= 1'b0;
            count_o     <= count_inc;
            src_q       <= src_q + STEP;
            dst_q       <= dst_q + STEP;
            // Abort is only honoured here, once the word is fully copied.
            if (count_inc == len_q || abort_i) begin
              bus_req_o <= 1'b0;
              done_o    <= 1'b1;
              aborted_o <= abort_i && (count_inc != len_q);
              state     <= DONE;
            end else begin
              mem_addr_o  <= src_q + STEP;
              mem_r_ena_o <= 1'b1;
              state       <= RD_REQ;
            end
          end
        end

        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_dma.sv
// tb_data_mem_dma: directed and randomized checks of data_mem_dma against a
// word-addressed memory responder with programmable stall and a copy model.
module tb_data_mem_dma;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic             bus_req;
  logic             gnt;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_w_data;
  logic             mem_w_ena;
  logic             mem_r_ena;
  logic [3:0]       mem_sign_mask;
  logic [31:0]      rdata;
  logic             stall;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [LEN_W-1:0] count;

  data_mem_dma #(.LEN_W(LEN_W)) dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .start_i        (start),
    .abort_i        (abort),
    .src_addr_i     (src_addr),
    .dst_addr_i     (dst_addr),
    .len_i          (len),
    .bus_req_o      (bus_req),
    .bus_gnt_i      (gnt),
    .mem_addr_o     (mem_addr),
    .mem_w_data_o   (mem_w_data),
    .mem_w_ena_o    (mem_w_ena),
    .mem_r_ena_o    (mem_r_ena),
    .mem_sign_mask_o(mem_sign_mask),
    .mem_r_data_i   (rdata),
    .mem_clk_stall_i(stall),
    .busy_o         (busy),
    .done_o         (done),
    .aborted_o      (aborted),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: untouched words read back as an address hash.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] peek(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Completed accesses in bus order.
  bit          lg_w [$];
  logic [31:0] lg_a [$];
  logic [31:0] lg_d [$];

  int          stall_mode = 0;  // <0: random 0..3 stall cycles per access
  int          total_stall = 0;
  int          k = 0;
  int          s_cur = 0;
  bit          prev_r = 1'b0;
  bit          prev_w = 1'b0;
  bit          done_now;
  logic [31:0] a_hold;
  logic [31:0] d_hold;
  logic [31:0] val;

  // Responder: stalls s_cur WAIT cycles beyond WAIT0, and returns inverted
  // data on every cycle except the one where the access completes.
  always @(negedge clk) begin
    if (!rst_n) begin
      k = 0; stall = 1'b0; prev_r = 1'b0; prev_w = 1'b0; rdata = '0;
    end else begin
      if (mem_r_ena || mem_w_ena) begin
        chk("ena_exclusive", 32'(mem_r_ena && mem_w_ena), 32'd0);
        chk("sign_mask", 32'(mem_sign_mask), 32'hF);
      end
      if ((mem_r_ena && !prev_r) || (mem_w_ena && !prev_w)) begin
        k = 0;
        s_cur = (stall_mode < 0) ? int'($urandom_range(0, 3)) : stall_mode;
        total_stall += s_cur;
        a_hold = mem_addr;
        d_hold = mem_w_data;
      end else if (mem_r_ena || mem_w_ena) begin
        k++;
        chk("addr_hold", mem_addr, a_hold);
        if (mem_w_ena) chk("wdata_hold", mem_w_data, d_hold);
      end
      if (mem_r_ena || mem_w_ena) begin
        stall = (s_cur > 0) && (k >= 1) && (k <= s_cur + 1);
        done_now = (k >= 2) && !stall;
        if (mem_r_ena) begin
          val = peek(mem_addr);
          rdata = done_now ? val : ~val;
        end
        if (done_now) begin
          lg_w.push_back(mem_w_ena);
          lg_a.push_back(mem_addr);
          lg_d.push_back(mem_w_ena ? mem_w_data : val);
          if (mem_w_ena) mem[mem_addr] = mem_w_data;
        end
      end else begin
        stall = 1'b0;
      end
      prev_r = mem_r_ena;
      prev_w = mem_w_ena;
    end
  end

  logic [31:0] exp_d [64];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic prep(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) exp_d[i] = peek(s + 32'(4 * i));
    lg_w.delete(); lg_a.delete(); lg_d.delete();
    total_stall = 0;
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n);
    src_addr = s; dst_addr = d; len = LEN_W'(n); start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick; cyc++; n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  // Model: word i is read from s+4i then written unchanged to d+4i.
  task automatic check_log(input logic [31:0] s, input logic [31:0] d, input int n);
    chk("access_count", 32'(lg_a.size()), 32'(2 * n));
    for (int i = 0; i < n; i++) begin
      if (2 * i + 1 < lg_a.size()) begin
        chk("rd_kind", 32'(lg_w[2*i]), 32'd0);
        chk("rd_addr", lg_a[2*i], s + 32'(4 * i));
        chk("rd_data", lg_d[2*i], exp_d[i]);
        chk("wr_kind", 32'(lg_w[2*i+1]), 32'd1);
        chk("wr_addr", lg_a[2*i+1], d + 32'(4 * i));
        chk("wr_data", lg_d[2*i+1], exp_d[i]);
        chk("dst_word", peek(d + 32'(4 * i)), exp_d[i]);
      end
    end
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int gdelay, input bit poke);
    int cyc;
    prep(s, n);
    gnt = (gdelay == 0);
    kick(s, d, n);
    cyc = 1;
    chk("arb_busy", 32'(busy), 32'd1);
    chk("arb_req", 32'(bus_req), 32'd1);
    for (int i = 0; i < gdelay; i++) begin
      chk("gnt_wait_req", 32'(bus_req), 32'd1);
      chk("gnt_wait_ena", 32'({mem_r_ena, mem_w_ena}), 32'd0);
      tick; cyc++;
    end
    gnt = 1'b1;
    tick; cyc++;
    chk("first_rd_ena", 32'(mem_r_ena), 32'd1);
    chk("first_rd_addr", mem_addr, s);
    if (poke) begin
      // A second start while busy must be ignored.
      src_addr = s + 32'h40; len = LEN_W'(n + 3); start = 1'b1;
      tick; cyc++;
      start = 1'b0;
    end
    wait_done(cyc);
    chk("count", 32'(count), 32'(n));
    chk("aborted_clear", 32'(aborted), 32'd0);
    chk("done_req_low", 32'(bus_req), 32'd0);
    chk("cycles", 32'(cyc), 32'(2 + gdelay + 6 * n + total_stall));
    tick;
    chk("done_one_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    check_log(s, d, n);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_ena"}, 32'({mem_r_ena, mem_w_ena}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_aborted"}, 32'(aborted), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_w_data, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_mask"}, 32'(mem_sign_mask), 32'hF);
  endtask

  initial begin
    int cyc;
    int n;
    logic [31:0] s;
    logic [31:0] d;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; gnt = 1'b1;
    src_addr = '0; dst_addr = '0; len = '0;
    tick; tick;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick;

    // Zero-stall basic copy.
    stall_mode = 0;
    run_copy(32'h1000, 32'h1100, 4, 0, 1'b0);

    // Five-stall responder.
    stall_mode = 5;
    run_copy(32'h2000, 32'h2100, 2, 0, 1'b0);

    // Grant withheld for 10 cycles.
    stall_mode = 0;
    run_copy(32'h3000, 32'h3100, 2, 10, 1'b0);

    // Start while busy is ignored.
    stall_mode = 1;
    run_copy(32'h4000, 32'h4100, 3, 0, 1'b1);

    // Address wrap past 2^32.
    run_copy(32'hFFFF_FFF8, 32'h0000_0500, 4, 1, 1'b0);

    // Abort during the second word's read.
    stall_mode = -1;
    prep(32'h5000, 8);
    gnt = 1'b1;
    kick(32'h5000, 32'h5100, 8);
    n = 0;
    while (!(mem_r_ena && mem_addr == 32'h5004) && n < 500) begin tick; n++; end
    chk("abort_reached_word2", mem_addr, 32'h5004);
    abort = 1'b1;
    cyc = 0;
    wait_done(cyc);
    chk("abort_count", 32'(count), 32'd2);
    chk("abort_flag", 32'(aborted), 32'd1);
    tick;
    abort = 1'b0;
    chk("abort_done_pulse", 32'(done), 32'd0);
    chk("abort_sticky", 32'(aborted), 32'd1);
    check_log(32'h5000, 32'h5100, 2);

    // Abort while waiting for grant.
    prep(32'h6000, 5);
    gnt = 1'b0;
    kick(32'h6000, 32'h6100, 5);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("arb_abort_done", 32'(done), 32'd1);
    chk("arb_abort_count", 32'(count), 32'd0);
    chk("arb_abort_flag", 32'(aborted), 32'd1);
    chk("arb_abort_req", 32'(bus_req), 32'd0);
    tick;
    chk("arb_abort_accesses", 32'(lg_a.size()), 32'd0);

    // Zero-length start: done pulse, no request; also clears aborted.
    len = '0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_req", 32'(bus_req), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_count", 32'(count), 32'd0);
    chk("len0_aborted_cleared", 32'(aborted), 32'd0);
    tick;
    chk("len0_done_pulse", 32'(done), 32'd0);
    chk("len0_req_after", 32'(bus_req), 32'd0);

    // Randomized copies.
    for (int t = 0; t < 6; t++) begin
      stall_mode = -1;
      s = $urandom & 32'hFFFF_FFFC;
      d = s ^ 32'h8000_0000;
      run_copy(s, d, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Async reset while the first write is stalled in its WAIT phase.
    stall_mode = 3;
    prep(32'h7000, 3);
    gnt = 1'b1;
    kick(32'h7000, 32'h7100, 3);
    n = 0;
    while (mem_w_ena !== 1'b1 && n < 200) begin tick; n++; end
    chk("rst_reached_write", 32'(mem_w_ena), 32'd1);
    tick; tick;
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    chk("rst_write_abandoned", 32'(mem.exists(32'h7100)), 32'd0);
    chk("rst_accesses", 32'(lg_a.size()), 32'd1);
    tick; tick;
    rst_n = 1'b1;
    tick;
    stall_mode = 0;
    run_copy(32'h7000, 32'h7100, 3, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
